thermo_keypad: RTL and testbench

THERMO_KEYPAD -- requirements
Module: thermo_keypad

---
 rtl/thermo_keypad.sv | 158 +++++++++++++++
 tb/tb_thermo_keypad.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/thermo_keypad.sv
// Debounced three-button keypad front end for the thermostat: one command pulse per press,
// with optional Up/Down auto-repeat enabled by defining THERMO_KEY_REPEAT_EN.
module thermo_keypad #(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 2
) (
  input  logic slowclock1,
  input  logic Reset,
  input  logic BtnUp,
  input  logic BtnDown,
  input  logic BtnSet,
  output logic Up,
  output logic Down,
  output logic Set,
  output logic RepeatActive
);

  localparam logic [7:0] DEB_C = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] RD_C  = 8'(REPEAT_DELAY);
  localparam logic [7:0] RP_C  = 8'(REPEAT_PERIOD);

`ifdef THERMO_KEY_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam logic [1:0] KEY_NONE = 2'd0;
  localparam logic [1:0] KEY_UP   = 2'd1;
  localparam logic [1:0] KEY_DOWN = 2'd2;
  localparam logic [1:0] KEY_SET  = 2'd3;

  typedef enum logic [2:0] {IDLE, DEBOUNCE, HOLD, REPEAT, RELEASE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]  key_q, key_d, cur_key;
  logic [2:0]  btn_p0, btn_p1;
  logic        fire, key_valid, all_low, same_key;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/p1: two-flop synchronizer on the raw buttons, bit order {Set, Down, Up}
  always_ff @(posedge slowclock1 or posedge Reset) begin
    if (Reset) begin
      btn_p0 <= 3'b000;
      btn_p1 <= 3'b000;
    end else begin
      btn_p0 <= {BtnSet, BtnDown, BtnUp};
      btn_p1 <= btn_p0;
    end
  end

  always_comb begin
    cur_key = KEY_NONE;
    case (btn_p1)
      3'b001:  cur_key = KEY_UP;
      3'b010:  cur_key = KEY_DOWN;
      3'b100:  cur_key = KEY_SET;
      default: cur_key = KEY_NONE;
    endcase
  end

  assign key_valid = (cur_key != KEY_NONE);
  assign all_low   = (btn_p1 == 3'b000);
  assign same_key  = key_valid && (cur_key == key_q);
  assign cnt_inc   = sat_inc(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          key_d = cur_key;
          if (DEB_C <= 8'd1) begin
            fire    = 1'b1;
            cnt_d   = 8'd0;
            state_d = HOLD;
          end else begin
            cnt_d   = 8'd1;
            state_d = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (all_low) begin
          state_d = IDLE;
        end else if (!same_key) begin
          state_d = RELEASE;
        end else if (cnt_inc >= DEB_C) begin
          fire    = 1'b1;
          cnt_d   = 8'd0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLD: begin
        // Set never repeats; without the repeat build Up/Down park here too
        if (all_low) begin
          state_d = IDLE;
        end else if (!same_key) begin
          state_d = RELEASE;
        end else if (REPEAT_EN && (key_q != KEY_SET) && (cnt_inc >= RD_C)) begin
          fire    = 1'b1;
          cnt_d   = 8'd0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REPEAT: begin
        if (all_low) begin
          state_d = IDLE;
        end else if (!same_key) begin
          state_d = RELEASE;
        end else if (cnt_inc >= RP_C) begin
          fire  = 1'b1;
          cnt_d = 8'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        if (all_low) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p2: FSM state and registered command outputs
  always_ff @(posedge slowclock1 or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      key_q        <= KEY_NONE;
      Up           <= 1'b0;
      Down         <= 1'b0;
      Set          <= 1'b0;
      RepeatActive <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      Up           <= fire && (key_d == KEY_UP);
      Down         <= fire && (key_d == KEY_DOWN);
      Set          <= fire && (key_d == KEY_SET);
      RepeatActive <= REPEAT_EN && (state_d == REPEAT);
    end
  end

endmodule

// File: tb/tb_thermo_keypad.sv
// Bench for thermo_keypad: press-duration model checked every cycle plus literal pulse-edge lists.
module tb_thermo_keypad;

  localparam int D  = 3;
  localparam int RD = 8;
  localparam int RP = 2;
`ifdef THERMO_KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic slowclock1 = 1'b0;
  logic Reset, BtnUp, BtnDown, BtnSet;
  logic Up, Down, Set, RepeatActive;

  thermo_keypad #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .slowclock1  (slowclock1),
    .Reset       (Reset),
    .BtnUp       (BtnUp),
    .BtnDown     (BtnDown),
    .BtnSet      (BtnSet),
    .Up          (Up),
    .Down        (Down),
    .Set         (Set),
    .RepeatActive(RepeatActive)
  );

  always #5 slowclock1 = ~slowclock1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge slowclock1) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: a press is a run of identical one-hot synchronized samples; pulses fall at
  // run lengths D, and for repeating keys at D+RD+k*RP. A change/conflict blocks until all low.
  logic [2:0] h1, h2, mkey, k_n, p_n;
  int         run, r_n;
  bit         blocked, b_n, ra_n;
  logic       exp_up, exp_down, exp_set, exp_ra;

  function automatic void model_step(input logic [2:0] s, input logic [2:0] key_i, input int run_i,
                                     input bit blk_i, output logic [2:0] key_o, output int run_o,
                                     output bit blk_o, output logic [2:0] pulse_o, output bit ra_o);
    key_o = key_i; run_o = run_i; blk_o = blk_i; pulse_o = 3'b000; ra_o = 1'b0;
    if (blk_i) begin
      if (s == 3'b000) blk_o = 1'b0;
      key_o = 3'b000; run_o = 0;
    end else if (key_i == 3'b000) begin
      if ($onehot(s)) begin key_o = s; run_o = 1; end
    end else if (s == 3'b000) begin
      key_o = 3'b000; run_o = 0;
    end else if (s != key_i) begin
      blk_o = 1'b1; key_o = 3'b000; run_o = 0;
    end else begin
      run_o = run_i + 1;
    end
    if (key_o != 3'b000) begin
      if (run_o == D) pulse_o = key_o;
      if (REP && key_o != 3'b100 && run_o >= D + RD) begin
        ra_o = 1'b1;
        if ((run_o - D - RD) % RP == 0) pulse_o = key_o;
      end
    end
  endfunction

  always @(posedge slowclock1 or posedge Reset) begin
    if (Reset) begin
      h1 <= '0; h2 <= '0; mkey <= '0; run <= 0; blocked <= 1'b0;
      exp_up <= 1'b0; exp_down <= 1'b0; exp_set <= 1'b0; exp_ra <= 1'b0;
    end else begin
      model_step(h2, mkey, run, blocked, k_n, r_n, b_n, p_n, ra_n);
      h1 <= {BtnSet, BtnDown, BtnUp};
      h2 <= h1;
      mkey <= k_n; run <= r_n; blocked <= b_n;
      exp_up <= p_n[0]; exp_down <= p_n[1]; exp_set <= p_n[2]; exp_ra <= ra_n;
    end
  end

  int   up_log[$], down_log[$], set_log[$], ra_log[$];
  logic ra_prev = 1'b0;

  always @(negedge slowclock1) begin
    chk("Up", Up, exp_up);
    chk("Down", Down, exp_down);
    chk("Set", Set, exp_set);
    chk("RepeatActive", RepeatActive, exp_ra);
    chk("onehot", ($countones({Up, Down, Set}) <= 1), 1);
    if (Up)   up_log.push_back(cyc);
    if (Down) down_log.push_back(cyc);
    if (Set)  set_log.push_back(cyc);
    if (RepeatActive && !ra_prev) ra_log.push_back(cyc);
    ra_prev <= RepeatActive;
  end

  task automatic check_log(input string name, input int got[$], input int base, input int want[$]);
    int sel[$];
    foreach (got[i]) if (got[i] > base) sel.push_back(got[i] - base);
    chk({name, " count"}, sel.size(), want.size());
    if (sel.size() == want.size())
      foreach (want[i]) chk({name, " edge"}, sel[i], want[i]);
  endtask

  task automatic idle_gap();
    BtnUp = 1'b0; BtnDown = 1'b0; BtnSet = 1'b0;
    repeat (6) @(negedge slowclock1);
  endtask

  int base;
  int w[$], none[$];

  initial begin
    none.delete();
    Reset = 1'b1; BtnUp = 1'b0; BtnDown = 1'b0; BtnSet = 1'b0;
    #1;
    chk("reset Up", Up, 0);
    chk("reset Down", Down, 0);
    chk("reset Set", Set, 0);
    chk("reset RepeatActive", RepeatActive, 0);
    repeat (3) @(negedge slowclock1);
    Reset = 1'b0;
    repeat (2) @(negedge slowclock1);

    // Single press, 6 edges
    base = cyc; BtnUp = 1'b1;
    repeat (6) @(negedge slowclock1);
    BtnUp = 1'b0;
    repeat (6) @(negedge slowclock1);
    w = '{5};
    check_log("press Up", up_log, base, w);
    check_log("press Down", down_log, base, none);
    check_log("press Set", set_log, base, none);
    idle_gap();

    // Bouncing Down button
    base = cyc;
    for (int i = 0; i < 8; i++) begin
      BtnDown = (i % 4) < 2;
      @(negedge slowclock1);
    end
    BtnDown = 1'b0;
    repeat (6) @(negedge slowclock1);
    check_log("bounce Down", down_log, base, none);
    idle_gap();

    // Long Up hold, 20 edges
    base = cyc; BtnUp = 1'b1;
    repeat (20) @(negedge slowclock1);
    BtnUp = 1'b0;
    repeat (8) @(negedge slowclock1);
    if (REP) w = '{5, 13, 15, 17, 19, 21}; else w = '{5};
    check_log("hold Up", up_log, base, w);
    if (REP) w = '{13}; else w.delete();
    check_log("hold RepeatActive", ra_log, base, w);
    idle_gap();

    // Set held 30 edges
    base = cyc; BtnSet = 1'b1;
    repeat (30) @(negedge slowclock1);
    BtnSet = 1'b0;
    repeat (6) @(negedge slowclock1);
    w = '{5};
    check_log("hold Set", set_log, base, w);
    check_log("hold Set RepeatActive", ra_log, base, none);
    idle_gap();

    // Set held long enough to saturate the counter
    base = cyc; BtnSet = 1'b1;
    repeat (300) @(negedge slowclock1);
    BtnSet = 1'b0;
    repeat (6) @(negedge slowclock1);
    w = '{5};
    check_log("saturate Set", set_log, base, w);
    idle_gap();

    // Two buttons pressed together never register
    base = cyc; BtnUp = 1'b1; BtnDown = 1'b1;
    repeat (10) @(negedge slowclock1);
    idle_gap();
    check_log("conflict Up", up_log, base, none);
    check_log("conflict Down", down_log, base, none);

    // Up into repeat, Down added, both released, fresh Down press
    base = cyc; BtnUp = 1'b1;
    repeat (13) @(negedge slowclock1);
    BtnDown = 1'b1;
    repeat (6) @(negedge slowclock1);
    BtnUp = 1'b0; BtnDown = 1'b0;
    repeat (4) @(negedge slowclock1);
    BtnDown = 1'b1;
    repeat (8) @(negedge slowclock1);
    BtnDown = 1'b0;
    repeat (6) @(negedge slowclock1);
    if (REP) w = '{5, 13, 15}; else w = '{5};
    check_log("change Up", up_log, base, w);
    w = '{28};
    check_log("change Down", down_log, base, w);
    idle_gap();

    // Reset just after edge 14 with Up held
    base = cyc; BtnUp = 1'b1;
    repeat (13) @(negedge slowclock1);
    @(posedge slowclock1);
    #1 Reset = 1'b1;
    #1;
    chk("midreset Up", Up, 0);
    chk("midreset Down", Down, 0);
    chk("midreset Set", Set, 0);
    chk("midreset RepeatActive", RepeatActive, 0);
    @(negedge slowclock1);
    if (REP) w = '{5, 13}; else w = '{5};
    check_log("prereset Up", up_log, base, w);
    Reset = 1'b0;
    base = cyc;
    repeat (8) @(negedge slowclock1);
    w = '{5};
    check_log("postreset Up", up_log, base, w);
    idle_gap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
